// File: rtl/vec_lsu_sequencer.sv
// Serialises scalar/vector load-store requests into one-word RAM accesses and reassembles load lanes.
// Store: n+1 cycles to resp, load: n+2, bounds error: 1; req_ready only in IDLE, response has no backpressure.
module vec_lsu_sequencer #(
  parameter int S     = 32,
  parameter int LANES = 6,
  parameter int V     = S * LANES,
  parameter int SIZE  = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic         req_vec,
  input  logic [S-1:0] req_addr,
  input  logic [V-1:0] req_wd,
  output logic         mem_we,
  output logic [S-1:0] mem_addr,
  output logic [S-1:0] mem_wd,
  input  logic [S-1:0] mem_rd,
  output logic         resp_valid,
  output logic [V-1:0] resp_rd,
  output logic         resp_err,
  output logic         busy
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt, idx_prv, last_idx;
  logic [S-1:0]    base;
  logic            vec_q;
  logic [V-1:0]    wd_q;
  logic [V-1:0]    rbuf, drain_v;
  logic [S:0]      end_addr;
  logic            req_err, accept, last_hit;

  // One extra bit on the end address so a base near 2^S cannot wrap into range.
  assign end_addr = {1'b0, req_addr} + (req_vec ? (S+1)'(LANES) : (S+1)'(1));
  assign req_err  = end_addr > (S+1)'(SIZE);
  assign accept   = req_valid && (state == IDLE);
  assign last_idx = vec_q ? IW'(LANES - 1) : '0;
  assign last_hit = (idx == last_idx);
  assign idx_nxt  = idx + 1'b1;
  assign idx_prv  = idx - 1'b1;

  always_comb begin
    drain_v = rbuf;
    drain_v[S*int'(last_idx) +: S] = mem_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)     state_nxt = RESP;
          else if (req_we) state_nxt = WRITE;
          else             state_nxt = READ;
        end
      end
      WRITE:   if (last_hit) state_nxt = RESP;
      READ:    if (last_hit) state_nxt = DRAIN;
      DRAIN:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    mem_we     = (state == WRITE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      base     <= '0;
      vec_q    <= 1'b0;
      wd_q     <= '0;
      rbuf     <= '0;
      resp_rd  <= '0;
      resp_err <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= '0;
            base  <= req_addr;
            vec_q <= req_vec;
            wd_q  <= req_wd;
            rbuf  <= '0;
            if (req_err) begin
              resp_rd  <= '0;
              resp_err <= 1'b1;
            end else begin
              mem_addr <= req_addr;
              if (req_we) mem_wd <= req_wd[S-1:0];
            end
          end
        end
        WRITE: begin
          if (last_hit) begin
            idx      <= '0;
            resp_rd  <= '0;
            resp_err <= 1'b0;
          end else begin
            idx      <= idx_nxt;
            mem_addr <= base + S'(idx_nxt);
            mem_wd   <= wd_q[S*int'(idx_nxt) +: S];
          end
        end
        READ: begin
          // RAM data lags the address by one cycle, so this cycle's word belongs to lane idx-1.
          if (idx != '0) rbuf[S*int'(idx_prv) +: S] <= mem_rd;
          if (last_hit) begin
            idx <= '0;
          end else begin
            idx      <= idx_nxt;
            mem_addr <= base + S'(idx_nxt);
          end
        end
        DRAIN: begin
          resp_rd  <= drain_v;
          resp_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_lsu_sequencer.sv
// Bench for vec_lsu_sequencer: randomized requests, queue scoreboard, behavioural 1-cycle RAM.
module tb_vec_lsu_sequencer;
  localparam int S = 32, LANES = 6, V = 192, SIZE = 14;

  logic         clk, rst;
  logic         req_valid, req_ready, req_we, req_vec;
  logic [S-1:0] req_addr;
  logic [V-1:0] req_wd;
  logic         mem_we;
  logic [S-1:0] mem_addr, mem_wd, mem_rd;
  logic         resp_valid, resp_err, busy;
  logic [V-1:0] resp_rd;

  vec_lsu_sequencer #(.S(S), .LANES(LANES), .V(V), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_vec(req_vec), .req_addr(req_addr), .req_wd(req_wd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_err(resp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [S-1:0] ram      [SIZE];
  logic [S-1:0] init_val [SIZE];
  logic [S-1:0] ref_mem  [SIZE];
  logic         init_ram;

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < SIZE; i++) ram[i] <= init_val[i];
    end else if (mem_we && mem_addr < SIZE) begin
      ram[mem_addr[3:0]] <= mem_wd;
    end
    mem_rd <= (mem_addr < SIZE) ? ram[mem_addr[3:0]] : '0;
  end

  typedef struct packed { logic [V-1:0] rd; logic err; logic [31:0] cyc; } resp_t;
  typedef struct packed { logic [S-1:0] addr; logic [S-1:0] dat; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  int checks = 0, errors = 0;
  int n_issued = 0, n_done = 0;
  int last_resp_cyc = -100;
  logic [V-1:0] last_rd;
  int cur_c = 0, cur_n = 0;
  logic [S-1:0] cur_base;
  bit cur_we = 0, cur_err = 0;
  bit mon_on = 0;

  task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  function automatic logic [V-1:0] rnd_vec();
    logic [V-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*S +: S] = $urandom;
    return v;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mon_on) begin
        int k;
        bit outst, exp_we;
        wr_t w;
        resp_t e;
        outst = (n_issued != n_done);
        k = cyc - cur_c;
        chk("req_ready", V'(req_ready), V'(!outst));
        chk("busy", V'(busy), V'(outst));
        exp_we = outst && cur_we && !cur_err && k >= 1 && k <= cur_n;
        chk("mem_we", V'(mem_we), V'(exp_we));
        if (mem_we) begin
          if (wq.size() == 0) fail_msg("unexpected_write");
          else begin
            w = wq.pop_front();
            chk("wr_addr", V'(mem_addr), V'(w.addr));
            chk("wr_data", V'(mem_wd), V'(w.dat));
          end
        end
        if (outst && !cur_we && !cur_err && k >= 1 && k <= cur_n)
          chk("rd_addr", V'(mem_addr), V'(cur_base + S'(k - 1)));
        if (resp_valid) begin
          if (rq.size() == 0) fail_msg("unexpected_resp");
          else begin
            e = rq.pop_front();
            chk("resp_rd", resp_rd, e.rd);
            chk("resp_err", V'(resp_err), V'(e.err));
            chk("resp_cycle", V'(cyc), V'(e.cyc));
          end
          n_done++;
          last_resp_cyc = cyc;
          last_rd = resp_rd;
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic issue(input bit we, input bit vec, input logic [S-1:0] addr,
                       input logic [V-1:0] wd, input bit b2b);
    int g;
    resp_t e;
    longint unsigned a, n;
    req_we = we; req_vec = vec; req_addr = addr; req_wd = wd; req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      fail_msg("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept_cycle", V'(cyc), V'(last_resp_cyc + 1));
    a = addr;
    n = vec ? LANES : 1;
    e.err = (a + n > SIZE);
    e.rd = '0;
    if (!e.err) begin
      for (int i = 0; i < int'(n); i++) begin
        if (we) begin
          wq.push_back('{addr: S'(a + i), dat: wd[i*S +: S]});
          ref_mem[int'(a) + i] = wd[i*S +: S];
        end else begin
          e.rd[i*S +: S] = ref_mem[int'(a) + i];
        end
      end
    end
    e.cyc = cyc + (e.err ? 1 : (we ? int'(n) + 1 : int'(n) + 2));
    rq.push_back(e);
    cur_c = cyc; cur_n = int'(n); cur_base = addr; cur_we = we; cur_err = e.err;
    @(posedge clk);
    n_issued++;
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_vec = 1'($urandom); req_addr = $urandom; req_wd = rnd_vec();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (n_issued != n_done && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) fail_msg("drain_timeout");
  endtask

  initial begin
    logic [V-1:0] v;
    logic [S-1:0] a;
    int gap;
    for (int i = 0; i < SIZE; i++) begin
      init_val[i] = $urandom;
      ref_mem[i]  = init_val[i];
    end
    init_ram = 1'b1;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_vec = 1'b0; req_addr = '0; req_wd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    init_ram = 1'b0;
    chk("rst_req_ready", V'(req_ready), V'(1));
    chk("rst_busy", V'(busy), V'(0));
    chk("rst_mem_we", V'(mem_we), V'(0));
    chk("rst_mem_addr", V'(mem_addr), V'(0));
    chk("rst_mem_wd", V'(mem_wd), V'(0));
    chk("rst_resp_valid", V'(resp_valid), V'(0));
    chk("rst_resp_err", V'(resp_err), V'(0));
    chk("rst_resp_rd", resp_rd, V'(0));
    rst = 1'b0;
    mon_on = 1'b1;
    fork monitor(); join_none

    // Scalar store
    issue(1'b1, 1'b0, 32'd3, {160'd0, 32'hDEADBEEF}, 1'b0);
    drain();
    @(negedge clk);
    chk("scalar_store_mem", V'(ram[3]), V'(32'hDEADBEEF));

    // Vector store then vector load at the top of memory
    v = {32'h66666666, 32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    issue(1'b1, 1'b1, 32'd8, v, 1'b0);
    issue(1'b0, 1'b1, 32'd8, rnd_vec(), 1'b1);
    drain();
    chk("vec_load_rd", last_rd, v);

    // Bounds
    issue(1'b0, 1'b1, 32'd9, rnd_vec(), 1'b0);
    issue(1'b1, 1'b0, 32'd13, rnd_vec(), 1'b1);
    issue(1'b0, 1'b0, 32'd14, rnd_vec(), 1'b1);
    issue(1'b1, 1'b0, 32'hFFFFFFFF, rnd_vec(), 1'b1);
    drain();

    // Scalar load zero-extends
    issue(1'b1, 1'b0, 32'd5, {160'd0, 32'hCAFEF00D}, 1'b0);
    issue(1'b0, 1'b0, 32'd5, rnd_vec(), 1'b1);
    drain();
    chk("scalar_load_rd", last_rd, {160'd0, 32'hCAFEF00D});

    // Reset in the middle of a vector store, after two words are written
    @(negedge clk);
    v = rnd_vec();
    req_we = 1'b1; req_vec = 1'b1; req_addr = '0; req_wd = v; req_valid = 1'b1;
    cur_c = cyc; cur_n = LANES; cur_base = '0; cur_we = 1'b1; cur_err = 1'b0;
    wq.push_back('{addr: 32'd0, dat: v[S-1:0]});
    wq.push_back('{addr: 32'd1, dat: v[2*S-1:S]});
    ref_mem[0] = v[S-1:0];
    ref_mem[1] = v[2*S-1:S];
    @(posedge clk);
    n_issued++;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    n_done++;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_idle_ready", V'(req_ready), V'(1));
    chk("abort_mem_we", V'(mem_we), V'(0));
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) chk("abort_mem_word", V'(ram[i]), V'(ref_mem[i]));

    // Two queued requests with req_valid held high
    issue(1'b1, 1'b1, 32'd2, rnd_vec(), 1'b0);
    issue(1'b0, 1'b1, 32'd2, rnd_vec(), 1'b1);

    for (int t = 0; t < 80; t++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      repeat (gap) @(negedge clk);
      case ($urandom_range(0, 9))
        0:       a = 32'hFFFFFFFF - $urandom_range(0, 6);
        1:       a = $urandom;
        default: a = $urandom_range(0, 15);
      endcase
      issue(1'($urandom), 1'($urandom), a, rnd_vec(), gap == 0);
    end
    drain();
    repeat (2) @(negedge clk);
    for (int i = 0; i < SIZE; i++) chk("final_mem_word", V'(ram[i]), V'(ref_mem[i]));
    chk("resp_queue_left", V'(rq.size()), V'(0));
    chk("write_queue_left", V'(wq.size()), V'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_lsu_sequencer.md
Name: vec_lsu_sequencer

Overview:
- Load/store sequencer directly upstream of the data memory array.
- Accepts one scalar (32-bit) or vector (6 x 32-bit) load/store request from the pipeline memory stage over a valid/ready handshake.
- Serialises each request into single-word accesses on a one-word, single-port synchronous RAM, and for loads reassembles the 192-bit result.
- Bounds-checks every request against the memory depth; out-of-range requests make no memory access.

Parameters:
- S, 32: word width in bits.
- V, 192: vector width in bits; V = S*LANES.
- LANES, 6: words per vector access.
- SIZE, 14: memory depth in words; legal word addresses are 0..SIZE-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_vec  in  1  1 = vector (LANES words), 0 = scalar (1 word).
- req_addr  in  S  base word address.
- req_wd  in  V  store data; lane i = req_wd[S*i+S-1:S*i]; scalar uses lane 0 only.
- mem_we  out  1  RAM write enable.
- mem_addr  out  S  RAM word address.
- mem_wd  out  S  RAM write data.
- mem_rd  in  S  RAM read data, valid the cycle after mem_addr is presented.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rd  out  V  load result; lane i from address base+i.
- resp_err  out  1  out-of-range flag, qualified by resp_valid.
- busy  out  1  request in progress (state != IDLE).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state = IDLE, req_ready = 1, mem_we = 0, mem_addr = 0, mem_wd = 0, resp_valid = 0, resp_err = 0, resp_rd = 0, busy = 0, lane index = 0.
- Handshake:
  - A request is accepted on the rising edge where req_valid and req_ready are both 1.
  - req_ready = 1 only in IDLE.
  - All request fields are latched at acceptance; later input changes are ignored.
  - resp has no backpressure.
- Bounds check (at acceptance):
  - n = LANES if req_vec, else 1.
  - Compute req_addr + n in S+1 bits.
  - Error if req_addr + n > SIZE; this also catches address wrap.
- FSM states: IDLE, WRITE, READ, DRAIN, RESP.
- IDLE, on acceptance:
  - Out of range → RESP with resp_err = 1; no mem_we and no address issued.
  - In range, store → WRITE.
  - In range, load → READ.
- WRITE:
  - For idx = 0..n-1, one per cycle: mem_we = 1, mem_addr = base+idx, mem_wd = lane idx.
  - After idx = n-1 → RESP.
- READ:
  - For idx = 0..n-1, one per cycle: mem_addr = base+idx, mem_we = 0.
  - Each cycle captures mem_rd into lane idx-1 (from idx = 1 onward).
  - After idx = n-1 → DRAIN.
- DRAIN: capture mem_rd into lane n-1 → RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, then → IDLE.
  - resp_rd holds the assembled lanes; unwritten lanes = 0 (scalar load: bits V-1:S = 0).
  - Store response: resp_rd = 0.
  - resp_rd and resp_err hold until the next RESP.
- Latency, with acceptance at edge T (cycle T+k = k cycles after):
  - Store: mem_we asserted during T+1..T+n; resp_valid in cycle T+n+1.
  - Load: addresses issued T+1..T+n; resp_valid in cycle T+n+2.
  - Error: resp_valid in cycle T+1.
- Idle outputs: outside WRITE, mem_we = 0; mem_addr and mem_wd hold their last values.
- Reset mid-operation:
  - Abort immediately; no further mem_we.
  - Words already written stay in memory.
  - No resp_valid for the aborted request.
- Back-to-back: req_valid held high is accepted again on the edge after the RESP cycle, i.e. the first IDLE cycle.

Test Plan:
1. Scalar store:
   - Stimulus: req_we = 1, req_vec = 0, addr = 3, req_wd[31:0] = 0xDEADBEEF.
   - Response: one mem_we pulse at addr 3 with data 0xDEADBEEF; resp_valid 2 cycles after acceptance; resp_err = 0.
2. Vector store then vector load, SIZE = 14:
   - Stimulus: vector store at addr 8 with lanes 0x11111111..0x66666666, then vector load at addr 8 (behavioural 1-cycle RAM model).
   - Response: writes to 8..13 in lane order; load resp_valid 8 cycles after acceptance with resp_rd equal to the stored vector.
3. Bounds:
   - Vector at addr 9 → resp_err = 1, resp_valid next cycle, zero mem_we pulses.
   - Scalar at addr 13 → legal.
   - Scalar at addr 14 → error.
   - Scalar at addr 0xFFFFFFFF → error; no wrap to 0.
4. Scalar load at addr 5 holding 0xCAFEF00D → resp_rd = {160'b0, 32'hCAFEF00D}, resp_valid 3 cycles after acceptance.
5. Reset mid vector store after 2 writes (addr 0, 1) → mem_we = 0 from the reset edge onward, no resp_valid, state IDLE, req_ready = 1; addrs 2..5 unchanged.
6. req_valid held high with two queued requests → req_ready low while busy, second request accepted exactly one cycle after the first resp_valid, no overlapping mem accesses.
